multiword_add_sequencer: RTL

//  Multi-cycle wide adder: adds two CHUNKS*CHUNK_WIDTH-bit operands on one narrow CLA adder, one chunk per clock.
//  The carry is registered between chunks, least-significant chunk first.

---
 rtl/multiword_add_sequencer_pkg.sv | 27 ++
 rtl/multiword_add_sequencer_cla.sv | 62 ++++++
 rtl/multiword_add_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM state encoding
// and a constant-evaluable ceiling log2 used to size the chunk index.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_GROUP_WIDTH = 4;
  localparam int DEFAULT_GROUP_COUNT = 2;
  localparam int DEFAULT_CHUNKS      = 4;

  // Never returns less than 1 so an index register always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_cla.sv
// Narrow chunk adder: carry-lookahead inside each group, carry rippled
// between groups.
import multiword_add_sequencer_pkg::*;

module ripple_block_CLA #(
  parameter int GROUP_WIDTH = DEFAULT_GROUP_WIDTH,
  parameter int GROUP_COUNT = DEFAULT_GROUP_COUNT,
  localparam int WIDTH      = GROUP_WIDTH * GROUP_COUNT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carryVec;
  logic             groupOut;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry inside a group is a flat sum-of-products of the group's
  // generate/propagate terms and the group carry-in; only group carries ripple.
  always_comb begin
    logic                 groupIn;
    logic                 lookahead;
    logic                 term;
    logic [GROUP_WIDTH:0] groupCarries;
    groupIn      = c_i;
    lookahead    = 1'b0;
    term         = 1'b0;
    groupCarries = '0;
    carryVec     = '0;
    for (int grp = 0; grp < GROUP_COUNT; grp++) begin
      for (int i = 0; i <= GROUP_WIDTH; i++) begin
        term = groupIn;
        for (int k = 0; k < i; k++) begin
          term = term & prop[grp*GROUP_WIDTH + k];
        end
        lookahead = term;
        for (int j = 0; j < i; j++) begin
          term = gen[grp*GROUP_WIDTH + j];
          for (int k = j + 1; k < i; k++) begin
            term = term & prop[grp*GROUP_WIDTH + k];
          end
          lookahead = lookahead | term;
        end
        groupCarries[i] = lookahead;
      end
      carryVec[grp*GROUP_WIDTH +: GROUP_WIDTH] = groupCarries[GROUP_WIDTH-1:0];
      groupIn = groupCarries[GROUP_WIDTH];
    end
    groupOut = groupIn;
  end

  assign s_o = prop ^ carryVec;
  assign c_o = groupOut;

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide adder built from one narrow CLA chunk adder: one chunk per clock,
// least-significant first, with the inter-chunk carry held in a register.
import multiword_add_sequencer_pkg::*;

module multiword_add_sequencer #(
  parameter int GROUP_WIDTH  = DEFAULT_GROUP_WIDTH,
  parameter int GROUP_COUNT  = DEFAULT_GROUP_COUNT,
  parameter int CHUNKS       = DEFAULT_CHUNKS,
  localparam int CHUNK_WIDTH = GROUP_WIDTH * GROUP_COUNT,
  localparam int TOTAL       = CHUNKS * CHUNK_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             carry_in,
  input  logic [TOTAL-1:0] x,
  input  logic [TOTAL-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [TOTAL-1:0] z,
  output logic             carry_out
);

  localparam int             IDX_W    = clog2(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TOTAL-1:0]   opX_q, opX_d;
  logic [TOTAL-1:0]   opY_q, opY_d;
  logic [TOTAL-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               carryOut_q, carryOut_d;

  logic [CHUNK_WIDTH-1:0] chunkA;
  logic [CHUNK_WIDTH-1:0] chunkB;
  logic [CHUNK_WIDTH-1:0] chunkSum;
  logic                   chunkCarry;

  assign chunkA = opX_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign chunkB = opY_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];

  ripple_block_CLA #(
    .GROUP_WIDTH(GROUP_WIDTH),
    .GROUP_COUNT(GROUP_COUNT)
  ) chunkAdder (
    .a_i(chunkA),
    .b_i(chunkB),
    .c_i(carry_q),
    .s_o(chunkSum),
    .c_o(chunkCarry)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      opX_q      <= '0;
      opY_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      opX_q      <= opX_d;
      opY_q      <= opY_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
    end
  end

  // The result register keeps its old contents until each chunk is overwritten,
  // and idx stops at the last chunk instead of wrapping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    opX_d      = opX_q;
    opY_d      = opY_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opX_d   = x;
          opY_d   = y;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = chunkSum;
        carry_d = chunkCarry;
        if (idx_q == LAST_IDX) begin
          carryOut_d = chunkCarry;
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign z         = sum_q;
  assign carry_out = carryOut_q;

endmodule
